// File: rtl/sd_cmd_serdes.sv
// SD CMD-line engine: frames and serialises a 48-bit command with CRC7, waits for
// the response start bit, deserialises short/long responses and checks them.
module sd_cmd_serdes #(
    parameter int RESP_LONG_BITS  = 136,
    parameter int RESP_SHORT_BITS = 48,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int NCC_CYCLES      = 8
) (
    input  logic                      clk_SD,
    input  logic                      reset_host,
    input  logic                      start,
    input  logic [5:0]                cmd_index,
    input  logic [31:0]               cmd_argument,
    input  logic [1:0]                resp_type,
    input  logic                      CMD_PIN_IN,
    output logic                      CMD_PIN_OUT,
    output logic                      CMD_OE,
    output logic                      busy,
    output logic                      done,
    output logic [RESP_LONG_BITS-1:0] response,
    output logic                      crc_error,
    output logic                      end_bit_error,
    output logic                      index_error,
    output logic                      timeout
);

    localparam int MAX_A = (RESP_LONG_BITS > TIMEOUT_CYCLES) ? RESP_LONG_BITS : TIMEOUT_CYCLES;
    localparam int MAX_B = (MAX_A > NCC_CYCLES) ? MAX_A : NCC_CYCLES;
    localparam int MAX_C = (MAX_B > 48) ? MAX_B : 48;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] C_ONE      = CW'(1);
    localparam logic [CW-1:0] C_HDR      = CW'(8);
    localparam logic [CW-1:0] C_TX_CRC   = CW'(40);
    localparam logic [CW-1:0] C_TX_END   = CW'(47);
    localparam logic [CW-1:0] C_TIMEOUT  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] C_NCC_LAST = CW'(NCC_CYCLES - 1);
    localparam logic [CW-1:0] C_LONG     = CW'(RESP_LONG_BITS);
    localparam logic [CW-1:0] C_SHORT    = CW'(RESP_SHORT_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_WAIT,
        S_RX,
        S_NCC
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [CW-1:0]             r_cnt;
    logic [39:0]               r_tx_data;
    logic [6:0]                r_crc;
    logic [5:0]                r_index;
    logic [1:0]                r_type;
    logic [RESP_LONG_BITS-1:0] r_resp;
    logic                      r_crc_err;
    logic                      r_end_err;
    logic                      r_idx_err;
    logic                      r_timeout;

    logic [CW-1:0]             w_cnt_inc;
    logic [CW-1:0]             w_rx_len;
    logic                      w_rx_last;
    logic                      w_rx_crc_en;
    logic                      w_expire;
    logic                      w_tx_bit;

    function automatic logic [6:0] f_crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    assign w_cnt_inc = r_cnt + C_ONE;
    assign w_rx_len  = (r_type == 2'd2) ? C_LONG : C_SHORT;
    assign w_rx_last = (w_cnt_inc == w_rx_len);
    // Long frames exclude the 8-bit header (start, transmission, reserved) from the CRC.
    assign w_rx_crc_en = (w_cnt_inc <= (w_rx_len - C_HDR)) &&
                         ((r_type != 2'd2) || (w_cnt_inc > C_HDR));
    assign w_expire  = CMD_PIN_IN && (w_cnt_inc == C_TIMEOUT);

    assign response      = r_resp;
    assign crc_error     = r_crc_err;
    assign end_bit_error = r_end_err;
    assign index_error   = r_idx_err;
    assign timeout       = r_timeout;

    always_ff @(posedge clk_SD or negedge reset_host) begin
        if (!reset_host) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        CMD_OE      = 1'b0;
        CMD_PIN_OUT = 1'b1;
        busy        = (r_state != S_IDLE);
        done        = 1'b0;
        w_tx_bit    = 1'b1;
        if (r_cnt < C_TX_CRC) begin
            w_tx_bit = r_tx_data[39];
        end else if (r_cnt < C_TX_END) begin
            w_tx_bit = r_crc[6];
        end
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_TX;
                end
            end
            S_TX: begin
                CMD_OE      = 1'b1;
                CMD_PIN_OUT = w_tx_bit;
                if (r_cnt == C_TX_END) begin
                    w_next = (r_type == 2'd0) ? S_NCC : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!CMD_PIN_IN) begin
                    w_next = S_RX;
                end else if (w_expire) begin
                    w_next = S_NCC;
                end
            end
            S_RX: begin
                if (w_rx_last) begin
                    w_next = S_NCC;
                end
            end
            S_NCC: begin
                done = (r_cnt == '0);
                if (r_cnt == C_NCC_LAST) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_SD or negedge reset_host) begin
        if (!reset_host) begin
            r_cnt     <= '0;
            r_tx_data <= '0;
            r_crc     <= '0;
            r_index   <= '0;
            r_type    <= '0;
            r_resp    <= '0;
            r_crc_err <= 1'b0;
            r_end_err <= 1'b0;
            r_idx_err <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_tx_data <= {1'b0, 1'b1, cmd_index, cmd_argument};
                        r_index   <= cmd_index;
                        r_type    <= resp_type;
                        r_crc     <= '0;
                        r_cnt     <= '0;
                        r_resp    <= '0;
                        r_crc_err <= 1'b0;
                        r_end_err <= 1'b0;
                        r_idx_err <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                S_TX: begin
                    if (r_cnt < C_TX_CRC) begin
                        r_crc     <= f_crc7_step(r_crc, r_tx_data[39]);
                        r_tx_data <= {r_tx_data[38:0], 1'b0};
                    end else begin
                        r_crc <= {r_crc[5:0], 1'b0};
                    end
                    if (r_cnt == C_TX_END) begin
                        r_cnt <= '0;
                        r_crc <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_WAIT: begin
                    if (!CMD_PIN_IN) begin
                        r_resp <= {r_resp[RESP_LONG_BITS-2:0], CMD_PIN_IN};
                        r_cnt  <= C_ONE;
                        r_crc  <= '0;
                    end else if (w_expire) begin
                        r_timeout <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RX: begin
                    r_resp <= {r_resp[RESP_LONG_BITS-2:0], CMD_PIN_IN};
                    if (w_rx_crc_en) begin
                        r_crc <= f_crc7_step(r_crc, CMD_PIN_IN);
                    end
                    // Flags use the pre-shift register: frame bit k sits at r_resp[k-1].
                    if (w_rx_last) begin
                        r_cnt     <= '0;
                        r_end_err <= ~CMD_PIN_IN;
                        r_crc_err <= (r_type != 2'd3) && (r_crc != r_resp[6:0]);
                        r_idx_err <= (r_type == 2'd1) &&
                                     (r_resp[45] || (r_resp[44:39] != r_index));
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_NCC: begin
                    r_cnt <= (r_cnt == C_NCC_LAST) ? '0 : w_cnt_inc;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_serdes.sv
// Scoreboard bench for sd_cmd_serdes: emulates the card on CMD_PIN_IN and checks
// transmitted frames, response capture, flags and transaction timing.
module tb_sd_cmd_serdes;

    localparam int LONG = 136;
    localparam int NCC  = 8;
    localparam int TMO  = 64;

    logic            clk_SD = 1'b0;
    logic            reset_host;
    logic            start;
    logic [5:0]      cmd_index;
    logic [31:0]     cmd_argument;
    logic [1:0]      resp_type;
    logic            CMD_PIN_IN;
    logic            CMD_PIN_OUT;
    logic            CMD_OE;
    logic            busy;
    logic            done;
    logic [LONG-1:0] response;
    logic            crc_error;
    logic            end_bit_error;
    logic            index_error;
    logic            timeout;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [47:0]  frame;
        logic [135:0] resp;
        logic [3:0]   flags;   // {crc, end, index, timeout}
    } res_t;

    typedef struct packed {
        int oe_cnt;
        int done_cyc;
        int ndone;
        int busy_low;
    } tim_t;

    typedef struct packed {
        res_t r;
        tim_t t;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];

    sd_cmd_serdes #(
        .RESP_LONG_BITS (LONG),
        .RESP_SHORT_BITS(48),
        .TIMEOUT_CYCLES (TMO),
        .NCC_CYCLES     (NCC)
    ) dut (
        .clk_SD       (clk_SD),
        .reset_host   (reset_host),
        .start        (start),
        .cmd_index    (cmd_index),
        .cmd_argument (cmd_argument),
        .resp_type    (resp_type),
        .CMD_PIN_IN   (CMD_PIN_IN),
        .CMD_PIN_OUT  (CMD_PIN_OUT),
        .CMD_OE       (CMD_OE),
        .busy         (busy),
        .done         (done),
        .response     (response),
        .crc_error    (crc_error),
        .end_bit_error(end_bit_error),
        .index_error  (index_error),
        .timeout      (timeout)
    );

    always #5 clk_SD = ~clk_SD;

    function automatic logic [6:0] crc7(input logic [135:0] v, input int n);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = v[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic rec_t mk_exp(input logic [5:0] idx, input logic [31:0] arg,
                                    input int done_cyc, input logic [135:0] resp,
                                    input logic [3:0] flags);
        rec_t e;
        e.r.frame    = {2'b01, idx, arg, crc7({96'b0, 2'b01, idx, arg}, 40), 1'b1};
        e.r.resp     = resp;
        e.r.flags    = flags;
        e.t.oe_cnt   = 48;
        e.t.done_cyc = done_cyc;
        e.t.ndone    = 1;
        e.t.busy_low = done_cyc + NCC;
        return e;
    endfunction

    function automatic logic [135:0] mk_short(input logic [5:0] idx, input logic [31:0] arg);
        return {88'b0, 2'b00, idx, arg, crc7({96'b0, 2'b00, idx, arg}, 40), 1'b1};
    endfunction

    // Drives one transaction as host and card; records what the DUT did in obs_q.
    task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                           input logic [135:0] reply, input int rlen, input int delay,
                           input int glitch);
        rec_t o;
        int   j;
        o = '0;
        o.t.done_cyc = -1;
        o.t.busy_low = -1;
        CMD_PIN_IN = 1'b1;
        @(negedge clk_SD);
        start = 1'b1; cmd_index = idx; cmd_argument = arg; resp_type = rt;
        @(negedge clk_SD);
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!busy) begin
                o.t.busy_low = c;
                break;
            end
            if (CMD_OE) begin
                o.r.frame = {o.r.frame[46:0], CMD_PIN_OUT};
                o.t.oe_cnt++;
            end
            if (done) begin
                o.t.ndone++;
                if (o.t.ndone == 1) begin
                    o.t.done_cyc = c;
                    o.r.resp     = response;
                    o.r.flags    = {crc_error, end_bit_error, index_error, timeout};
                end
            end
            j = c - (48 + delay);
            CMD_PIN_IN = (rlen > 0 && j >= 0 && j < rlen) ? reply[rlen-1-j] : 1'b1;
            if (c == glitch) begin
                start = 1'b1; cmd_index = ~idx; cmd_argument = ~arg; resp_type = 2'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk_SD);
        end
        start = 1'b0;
        CMD_PIN_IN = 1'b1;
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        reset_host = 1'b0; start = 1'b0; CMD_PIN_IN = 1'b1;
        cmd_index = '0; cmd_argument = '0; resp_type = '0;
        repeat (2) @(negedge clk_SD);
        checks++;
        if ({CMD_PIN_OUT, CMD_OE, busy, done, crc_error, end_bit_error, index_error, timeout} !== 8'b1000_0000
            || response !== '0) begin
            failures++;
            $display("FAIL reset got pin/oe/busy/done/flags=%b%b%b%b%b%b%b%b resp=%h required 10000000 resp=0",
                     CMD_PIN_OUT, CMD_OE, busy, done, crc_error, end_bit_error, index_error, timeout, response);
        end
        reset_host = 1'b1;
        @(negedge clk_SD);
    endtask

    task automatic test_cmd0();
        rec_t e, o;
        e = mk_exp(6'd0, 32'h0, 48, '0, 4'b0000);
        e.r.frame = 48'h400000000095;
        exp_q.push_back(e);
        run_txn(6'd0, 32'h0, 2'd0, '0, 0, 0, -1);
        o = obs_q.pop_front(); e = exp_q.pop_front();
        checks += 2;
        if (o.r !== e.r) begin
            failures++;
            $display("FAIL cmd0_result got frame=%h resp=%h flags=%b required frame=%h resp=%h flags=%b",
                     o.r.frame, o.r.resp, o.r.flags, e.r.frame, e.r.resp, e.r.flags);
        end
        if (o.t !== e.t) begin
            failures++;
            $display("FAIL cmd0_timing got oe=%0d done@%0d ndone=%0d idle@%0d required oe=%0d done@%0d ndone=%0d idle@%0d",
                     o.t.oe_cnt, o.t.done_cyc, o.t.ndone, o.t.busy_low, e.t.oe_cnt, e.t.done_cyc, e.t.ndone, e.t.busy_low);
        end
    endtask

    task automatic test_short_resp(input string name, input logic [47:0] reply, input int delay,
                                   input logic [3:0] flags);
        rec_t e, o;
        e = mk_exp(6'd8, 32'h1AA, 48 + delay + 48, {88'b0, reply}, flags);
        exp_q.push_back(e);
        run_txn(6'd8, 32'h1AA, 2'd1, {88'b0, reply}, 48, delay, -1);
        o = obs_q.pop_front(); e = exp_q.pop_front();
        checks += 2;
        if (o.r !== e.r) begin
            failures++;
            $display("FAIL %s_result got frame=%h resp=%h flags=%b required frame=%h resp=%h flags=%b",
                     name, o.r.frame, o.r.resp, o.r.flags, e.r.frame, e.r.resp, e.r.flags);
        end
        if (o.t !== e.t) begin
            failures++;
            $display("FAIL %s_timing got oe=%0d done@%0d ndone=%0d idle@%0d required oe=%0d done@%0d ndone=%0d idle@%0d",
                     name, o.t.oe_cnt, o.t.done_cyc, o.t.ndone, o.t.busy_low, e.t.oe_cnt, e.t.done_cyc, e.t.ndone, e.t.busy_low);
        end
    endtask

    task automatic test_long_resp();
        rec_t           e, o;
        logic [119:0]   pl;
        logic [135:0]   reply;
        for (int i = 0; i < 4; i++) pl[i*30 +: 30] = 30'($urandom);
        reply = {8'h3F, pl, crc7({16'b0, pl}, 120), 1'b1};
        e = mk_exp(6'd2, 32'h0, 48 + 3 + 136, reply, 4'b0000);
        exp_q.push_back(e);
        run_txn(6'd2, 32'h0, 2'd2, reply, 136, 3, -1);
        o = obs_q.pop_front(); e = exp_q.pop_front();
        checks += 2;
        if (o.r !== e.r) begin
            failures++;
            $display("FAIL long_result got frame=%h resp=%h flags=%b required frame=%h resp=%h flags=%b",
                     o.r.frame, o.r.resp, o.r.flags, e.r.frame, e.r.resp, e.r.flags);
        end
        if (o.t !== e.t) begin
            failures++;
            $display("FAIL long_timing got oe=%0d done@%0d idle@%0d required oe=%0d done@%0d idle@%0d",
                     o.t.oe_cnt, o.t.done_cyc, o.t.busy_low, e.t.oe_cnt, e.t.done_cyc, e.t.busy_low);
        end
    endtask

    task automatic test_r3_no_check();
        rec_t         e, o;
        logic [135:0] reply;
        reply = {88'b0, 2'b00, 6'h3F, 32'h80FF8000, 7'h7F, 1'b1};
        e = mk_exp(6'd41, 32'h40300000, 48 + 2 + 48, reply, 4'b0000);
        exp_q.push_back(e);
        run_txn(6'd41, 32'h40300000, 2'd3, reply, 48, 2, -1);
        o = obs_q.pop_front(); e = exp_q.pop_front();
        checks++;
        if (o.r !== e.r || o.t !== e.t) begin
            failures++;
            $display("FAIL r3_result got resp=%h flags=%b done@%0d required resp=%h flags=%b done@%0d",
                     o.r.resp, o.r.flags, o.t.done_cyc, e.r.resp, e.r.flags, e.t.done_cyc);
        end
    endtask

    task automatic test_timeout();
        rec_t e, o;
        e = mk_exp(6'd55, 32'h0, 48 + TMO, '0, 4'b0001);
        exp_q.push_back(e);
        run_txn(6'd55, 32'h0, 2'd1, '0, 0, 0, -1);
        o = obs_q.pop_front(); e = exp_q.pop_front();
        checks += 2;
        if (o.r !== e.r) begin
            failures++;
            $display("FAIL timeout_result got frame=%h resp=%h flags=%b required frame=%h resp=%h flags=%b",
                     o.r.frame, o.r.resp, o.r.flags, e.r.frame, e.r.resp, e.r.flags);
        end
        if (o.t !== e.t) begin
            failures++;
            $display("FAIL timeout_timing got done@%0d ndone=%0d idle@%0d required done@%0d ndone=%0d idle@%0d",
                     o.t.done_cyc, o.t.ndone, o.t.busy_low, e.t.done_cyc, e.t.ndone, e.t.busy_low);
        end
    endtask

    task automatic test_reset_mid_tx();
        @(negedge clk_SD);
        start = 1'b1; cmd_index = 6'd0; cmd_argument = 32'h0; resp_type = 2'd1;
        @(negedge clk_SD);
        start = 1'b0;
        repeat (20) @(negedge clk_SD);
        checks++;
        if ({CMD_OE, CMD_PIN_OUT} !== 2'b10) begin
            failures++;
            $display("FAIL midtx_bit20 got oe/pin=%b%b required 10", CMD_OE, CMD_PIN_OUT);
        end
        reset_host = 1'b0;
        #1;
        checks++;
        if ({CMD_OE, CMD_PIN_OUT, busy, done} !== 4'b0100) begin
            failures++;
            $display("FAIL midtx_reset got oe/pin/busy/done=%b%b%b%b required 0100",
                     CMD_OE, CMD_PIN_OUT, busy, done);
        end
        @(negedge clk_SD);
        reset_host = 1'b1;
        @(negedge clk_SD);
    endtask

    task automatic test_ignore_start();
        rec_t e, o;
        e = mk_exp(6'd8, 32'h1AA, 48 + 2 + 48, {88'b0, 48'h08000001AA13}, 4'b0000);
        exp_q.push_back(e);
        run_txn(6'd8, 32'h1AA, 2'd1, {88'b0, 48'h08000001AA13}, 48, 2, 10);
        o = obs_q.pop_front(); e = exp_q.pop_front();
        checks += 2;
        if (o.r !== e.r) begin
            failures++;
            $display("FAIL ignore_start_result got frame=%h resp=%h flags=%b required frame=%h resp=%h flags=%b",
                     o.r.frame, o.r.resp, o.r.flags, e.r.frame, e.r.resp, e.r.flags);
        end
        if (o.t !== e.t) begin
            failures++;
            $display("FAIL ignore_start_timing got oe=%0d done@%0d idle@%0d required oe=%0d done@%0d idle@%0d",
                     o.t.oe_cnt, o.t.done_cyc, o.t.busy_low, e.t.oe_cnt, e.t.done_cyc, e.t.busy_low);
        end
        repeat (3) @(negedge clk_SD);
        checks++;
        if ({busy, CMD_OE} !== 2'b00) begin
            failures++;
            $display("FAIL ignore_start_queued got busy/oe=%b%b required 00", busy, CMD_OE);
        end
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_short_resp("r7_ok",      48'h08000001AA13, 5, 4'b0000);
        test_short_resp("r7_crc",     48'h08000001AA11, 5, 4'b1000);
        test_short_resp("r7_idx9",    mk_short(6'd9, 32'h1AA), 5, 4'b0010);
        test_short_resp("r7_endbit",  48'h08000001AA12, 4, 4'b0100);
        test_short_resp("r7_lastwin", 48'h08000001AA13, TMO - 1, 4'b0000);
        test_long_resp();
        test_r3_no_check();
        test_timeout();
        test_reset_mid_tx();
        test_ignore_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
